// File: rtl/pong_vga_renderer.sv
// Pong VGA renderer: 640x480@60 Hz timing generator with per-frame snapshot of game state
// and a fixed-priority pixel colour mux; every output is registered one cycle behind the counters.
module pong_vga_renderer #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_HEIGHT = 60,
  parameter int BALL_SIZE     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] player_paddle_y,
  input  logic [9:0] opponent_paddle_y,
  input  logic [9:0] current_ball_x,
  input  logic [9:0] current_ball_y,
  input  logic [7:0] score,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue,
  output logic       video_active,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SNAP    = 10'(V_VISIBLE);
  localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] PAD_W     = 11'(PADDLE_WIDTH);
  localparam logic [10:0] PAD_H     = 11'(PADDLE_HEIGHT);
  localparam logic [10:0] PLY_X     = 11'(H_VISIBLE - PADDLE_WIDTH);
  localparam logic [10:0] BALL_W    = 11'(BALL_SIZE);

  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;
  logic [9:0] snap_player_r;
  logic [9:0] snap_opp_r;
  logic [9:0] snap_ball_x_r;
  logic [9:0] snap_ball_y_r;
  logic [7:0] snap_score_r;

  logic        snap_s;
  logic [10:0] x_s;
  logic [10:0] y_s;
  logic [10:0] opp_off_s;
  logic [10:0] ply_off_s;
  logic        visible_s;
  logic        ball_s;
  logic        opp_pad_s;
  logic        ply_pad_s;
  logic        score_row_s;
  logic        opp_score_s;
  logic        ply_score_s;
  logic        net_s;
  logic        hsync_s;
  logic        vsync_s;
  logic [5:0]  rgb_s;

  assign snap_s = (h_cnt_r == 10'd0) && (v_cnt_r == V_SNAP);

  // Pixel and line counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= (v_cnt_r == V_LAST) ? 10'd0 : v_cnt_r + 10'd1;
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Game-state snapshot, taken once per frame at the start of vertical blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_player_r <= 10'd210;
      snap_opp_r    <= 10'd240;
      snap_ball_x_r <= 10'd320;
      snap_ball_y_r <= 10'd240;
      snap_score_r  <= 8'd0;
    end else if (snap_s) begin
      snap_player_r <= player_paddle_y;
      snap_opp_r    <= opponent_paddle_y;
      snap_ball_x_r <= current_ball_x;
      snap_ball_y_r <= current_ball_y;
      snap_score_r  <= score;
    end
  end

  // Object hit tests; 11-bit arithmetic keeps top+size from wrapping
  always_comb begin
    x_s       = {1'b0, h_cnt_r};
    y_s       = {1'b0, v_cnt_r};
    opp_off_s = x_s - 11'd40;
    ply_off_s = x_s - 11'd360;
    visible_s = (x_s < H_VIS) && (y_s < V_VIS);
    hsync_s   = !((x_s >= HS_START) && (x_s < HS_END));
    vsync_s   = !((y_s >= VS_START) && (y_s < VS_END));
    ball_s    = (x_s >= {1'b0, snap_ball_x_r}) && (x_s < {1'b0, snap_ball_x_r} + BALL_W) &&
                (y_s >= {1'b0, snap_ball_y_r}) && (y_s < {1'b0, snap_ball_y_r} + BALL_W);
    opp_pad_s = (x_s < PAD_W) &&
                (y_s >= {1'b0, snap_opp_r}) && (y_s < {1'b0, snap_opp_r} + PAD_H);
    ply_pad_s = (x_s >= PLY_X) &&
                (y_s >= {1'b0, snap_player_r}) && (y_s < {1'b0, snap_player_r} + PAD_H);
    score_row_s = (y_s >= 11'd8) && (y_s < 11'd24);
    // Each score point is a 12-px block on a 16-px pitch
    opp_score_s = score_row_s && (x_s >= 11'd40) &&
                  (opp_off_s[10:4] < {3'b000, snap_score_r[7:4]}) && (opp_off_s[3:0] < 4'd12);
    ply_score_s = score_row_s && (x_s >= 11'd360) &&
                  (ply_off_s[10:4] < {3'b000, snap_score_r[3:0]}) && (ply_off_s[3:0] < 4'd12);
    net_s = (x_s >= 11'd318) && (x_s <= 11'd321) && !y_s[4];
  end

  // Colour priority mux, forced black outside the visible area
  always_comb begin
    rgb_s = 6'b000000;
    if (!visible_s) begin
      rgb_s = 6'b000000;
    end else if (ball_s) begin
      rgb_s = 6'b111111;
    end else if (ply_pad_s) begin
      rgb_s = 6'b001100;
    end else if (opp_pad_s) begin
      rgb_s = 6'b110000;
    end else if (opp_score_s || ply_score_s) begin
      rgb_s = 6'b111100;
    end else if (net_s) begin
      rgb_s = 6'b010101;
    end else begin
      rgb_s = 6'b000000;
    end
  end

  // Registered outputs, all aligned one cycle behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      red          <= 2'b00;
      green        <= 2'b00;
      blue         <= 2'b00;
      video_active <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      hsync        <= hsync_s;
      vsync        <= vsync_s;
      red          <= rgb_s[5:4];
      green        <= rgb_s[3:2];
      blue         <= rgb_s[1:0];
      video_active <= visible_s;
      frame_tick   <= snap_s;
    end
  end

endmodule
